// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared constants and FSM encoding for the sequential binary-to-BCD converter.
// Holds the digit width, add-3 correction constants and the IDLE/CONV state type.
package bin_to_bcd_seq_pkg;

    localparam int unsigned BCD_W       = 4;
    localparam logic [3:0]  ADD3_THRESH = 4'd5;
    localparam logic [3:0]  ADD3_VAL    = 4'd3;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble correction for one BCD digit: adds 3 when the digit is 5 or more.
// Ports: digit (4-bit in), adj (4-bit corrected out); purely combinational.
module bcd_add3_digit
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adj
);

    // Values of 5..9 map to 8..12, which stays inside 4 bits.
    assign adj = (digit >= ADD3_THRESH) ? digit + ADD3_VAL : digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Ports: clk, rst_n, start, bin[BIN_W] in; busy, done, bcd[4*DIGITS] out.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CW = $clog2(BIN_W + 1);
    localparam int SW = BCD_W * DIGITS;

    // Too few digits would silently drop high-order bits of the result.
    if ((64'd10 ** DIGITS) <= ((64'd1 << BIN_W) - 64'd1)) begin : g_bad_digits
        $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
    end

    state_t            state;
    state_t            state_n;
    logic [BIN_W-1:0]  shreg;
    logic [SW-1:0]     scratch;
    logic [CW-1:0]     cnt;
    logic [SW-1:0]     bcd_r;
    logic              done_r;

    logic [SW-1:0]       corr;
    logic [SW+BIN_W-1:0] cat;
    logic [SW-1:0]       scratch_sh;
    logic [BIN_W-1:0]    shreg_sh;
    logic                last;
    logic                load;

    for (genvar i = 0; i < DIGITS; i++) begin : g_add3
        bcd_add3_digit u_add3 (
            .digit (scratch[BCD_W*i +: BCD_W]),
            .adj   (corr[BCD_W*i +: BCD_W])
        );
    end

    // The bit leaving the scratch MSB is dropped by the shift.
    assign cat        = {corr, shreg} << 1;
    assign scratch_sh = cat[SW+BIN_W-1:BIN_W];
    assign shreg_sh   = cat[BIN_W-1:0];
    assign last       = (cnt == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_n = CONV;
                end
            end
            CONV: begin
                if (last) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            scratch <= '0;
            cnt     <= '0;
            bcd_r   <= '0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (load) begin
                shreg   <= bin;
                scratch <= '0;
                cnt     <= CW'(BIN_W);
            end else if (state == CONV) begin
                shreg   <= shreg_sh;
                scratch <= scratch_sh;
                cnt     <= cnt - CW'(1);
                if (last) begin
                    bcd_r  <= scratch_sh;
                    done_r <= 1'b1;
                end
            end
        end
    end

    assign busy = (state == CONV);
    assign done = done_r;
    assign bcd  = bcd_r;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq (8-bit/3-digit and 16-bit/5-digit).
// Checks handshake timing, results, ignored starts, reset abort and back-to-back use.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start8 = 1'b0;
    logic [7:0]  bin8 = '0;
    logic        busy8;
    logic        done8;
    logic [11:0] bcd8;

    logic        start16 = 1'b0;
    logic [15:0] bin16 = '0;
    logic        busy16;
    logic        done16;
    logic [19:0] bcd16;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .bin   (bin8),
        .busy  (busy8),
        .done  (done8),
        .bcd   (bcd8)
    );

    bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start16),
        .bin   (bin16),
        .busy  (busy16),
        .done  (done16),
        .bcd   (bcd16)
    );

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0: seg = 7'b1111110;
            4'd1: seg = 7'b0110000;
            4'd2: seg = 7'b1101101;
            4'd3: seg = 7'b1111001;
            4'd4: seg = 7'b0110011;
            4'd5: seg = 7'b1011011;
            4'd6: seg = 7'b1011111;
            4'd7: seg = 7'b1110000;
            4'd8: seg = 7'b1111111;
            4'd9: seg = 7'b1111011;
            default: seg = 7'b0000000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run8(input string tag, input logic [7:0] b,
                        input logic [11:0] exp);
        int bad;
        bad = 0;
        start8 = 1'b1;
        bin8 = b;
        cyc();
        start8 = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            bin8 = ~b;
            if (!(busy8 === 1'b1 && done8 === 1'b0)) bad++;
            cyc();
        end
        chk({tag, " busy window"}, bad, 0);
        chk({tag, " done"}, done8, 1);
        chk({tag, " busy in done"}, busy8, 0);
        chk({tag, " bcd"}, bcd8, exp);
        cyc();
        chk({tag, " done width"}, done8, 0);
        chk({tag, " bcd hold"}, bcd8, exp);
    endtask

    task automatic run16(input string tag, input logic [15:0] b,
                         input logic [19:0] exp);
        int bad;
        bad = 0;
        start16 = 1'b1;
        bin16 = b;
        cyc();
        start16 = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            if (!(busy16 === 1'b1 && done16 === 1'b0)) bad++;
            cyc();
        end
        chk({tag, " busy window"}, bad, 0);
        chk({tag, " done"}, done16, 1);
        chk({tag, " bcd"}, bcd16, exp);
        cyc();
        chk({tag, " done width"}, done16, 0);
    endtask

    initial begin
        int bad;
        int seen;

        // Reset state
        #12;
        chk("rst busy", busy8, 0);
        chk("rst done", done8, 0);
        chk("rst bcd", bcd8, 0);
        chk("rst bcd16", bcd16, 0);
        rst_n = 1'b1;
        cyc();

        // 1: full-scale value
        run8("t1 255", 8'd255, 12'h255);

        // 2: zero and 99 with decoder check on units digit
        run8("t2 0", 8'd0, 12'h000);
        run8("t2 99", 8'd99, 12'h099);
        chk("t2 seg units", seg(bcd8[3:0]), 7'b1111011);

        // 3: start held high -> a result every 9 cycles
        start8 = 1'b1;
        bin8 = 8'd128;
        cyc();
        for (int r = 0; r < 3; r++) begin
            bad = 0;
            for (int i = 1; i <= 8; i++) begin
                if (!(busy8 === 1'b1 && done8 === 1'b0)) bad++;
                cyc();
            end
            if (r == 2) start8 = 1'b0;
            chk("t3 busy window", bad, 0);
            chk("t3 done", done8, 1);
            chk("t3 busy low", busy8, 0);
            chk("t3 bcd", bcd8, 12'h128);
            cyc();
        end
        chk("t3 stop", busy8, 0);

        // 4: starts while busy are ignored
        start8 = 1'b1;
        bin8 = 8'd42;
        cyc();
        start8 = 1'b0;
        cyc();
        cyc();
        start8 = 1'b1;
        bin8 = 8'd7;
        for (int i = 3; i <= 6; i++) cyc();
        start8 = 1'b0;
        cyc();
        cyc();
        chk("t4 done", done8, 1);
        chk("t4 bcd", bcd8, 12'h042);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (busy8 !== 1'b0 || done8 !== 1'b0) seen++;
        end
        chk("t4 no second", seen, 0);
        chk("t4 bcd hold", bcd8, 12'h042);

        // 5: reset mid-conversion aborts at once
        start8 = 1'b1;
        bin8 = 8'd200;
        cyc();
        start8 = 1'b0;
        cyc();
        cyc();
        cyc();
        rst_n = 1'b0;
        #1;
        chk("t5 busy", busy8, 0);
        chk("t5 done", done8, 0);
        chk("t5 bcd", bcd8, 0);
        cyc();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (done8 !== 1'b0 || busy8 !== 1'b0) seen++;
        end
        chk("t5 no done", seen, 0);
        run8("t5 17", 8'd17, 12'h017);

        // 6: 16-bit / 5-digit instance
        run16("t6 ffff", 16'hFFFF, 20'h65535);
        run16("t6 10000", 16'd10000, 20'h10000);
        run16("t6 1", 16'd1, 20'h00001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
